matrix_wakeup_unit: RTL and testbench
=====================================

Name: matrix_wakeup_unit

Overview:
- Parametrised, register-owning successor to the scheduler's matrix wakeup path.
- Holds per-entry valid bits, an ENTRY_NUM x ENTRY_NUM producer dependency matrix and the outstanding-store bit vector.
- Produces per-entry operand-ready flags consumed by select logic.
- New relative to the previous generation:
  - configurable load/store ordering mode
  - same-cycle dispatch/wakeup bypass
  - explicit flush
  - optional speculative-wakeup cancel

Parameters:
- ENTRY_NUM, 16, issue queue entries; IDX_W = $clog2(ENTRY_NUM)
- DISPATCH_WIDTH, 2, dispatch lanes; lane 0 is oldest
- SRC_NUM, 2, source operands per instruction
- WAKEUP_NUM, 3, wakeup vectors per cycle (register plus store issue combined)
- STORE_DEP_MODE, 1, load ordering: 0 = none, 1 = predicted loads only, 2 = every load waits for all older stores

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  clear all entries and the store vector
- dispatch_valid  in  DISPATCH_WIDTH  lane writes entry
- dispatch_ptr  in  DISPATCH_WIDTH*IDX_W  target entry per lane
- dispatch_src_wait  in  DISPATCH_WIDTH*SRC_NUM  source not ready in ready-bit table
- dispatch_src_ptr  in  DISPATCH_WIDTH*SRC_NUM*IDX_W  producer entry per source
- dispatch_store  in  DISPATCH_WIDTH  lane is a store
- dispatch_load  in  DISPATCH_WIDTH  lane is a load
- dispatch_mdp  in  DISPATCH_WIDTH  memory-dependence predictor says "wait"
- wakeup_vec  in  WAKEUP_NUM*ENTRY_NUM  one-hot producer entries broadcasting
- release_vec  in  ENTRY_NUM  entries leaving the queue this cycle
- op_ready  out  ENTRY_NUM  entry valid and no pending producer

Behaviour:
- Reset (rst_n=0, asynchronous): valid, matrix, store vector and cancel shadow are all 0; op_ready = 0.
- op_ready[e] = valid[e] & ~|row[e]. Purely combinational from registers, so it changes only after a clock edge.
- Wake mask W = OR of all wakeup_vec slices. At each edge, every row clears the bits in W.
- Dispatch, lane i, entry d:
  - valid[d] <= 1.
  - row[d] <= OR over sources j with dispatch_src_wait of onehot(dispatch_src_ptr), plus storeDep_i, then AND ~W (same-cycle bypass).
  - Column d is cleared in every other row (stale reuse).
- storeDep_i:
  - mode 0: 0.
  - mode 1: store vector if dispatch_load & dispatch_mdp, else 0.
  - mode 2: store vector if dispatch_load, else 0.
  - The store vector seen by lane i includes stores dispatched on lanes < i this cycle and excludes released entries.
- Store vector next = (storeVec & ~release_vec) | OR of onehot(dispatch_ptr) over store lanes.
- release_vec clears valid and the store bit. The row is left as is and is rewritten on the next dispatch.
- Precedence per entry: flush > dispatch > release. Dispatch and release of the same entry in one cycle: the entry ends valid.
- A src_ptr equal to the lane's own entry, or a src_ptr of an invalid entry, is a caller error. No check is required; behaviour is undefined.
- flush: valid and store vector cleared at the next edge; the matrix is left as is. Dispatch in the same cycle is ignored.
- Latency: dispatch with no dependencies gives op_ready=1 one cycle later. Wakeup at cycle t gives op_ready at t+1.

Optional Feature:
- Macro RSD_MATRIX_WAKEUP_CANCEL_EN.
- When defined, adds ports:
  - cancel_valid  in  1
  - cancel_vec  in  ENTRY_NUM
- A per-row shadow register records the bits cleared by wakeup in the previous cycle.
- On cancel_valid, each row re-sets its shadowed bits that are also in cancel_vec. This restore takes priority over a new wakeup of the same bit in that cycle.
- The shadow is cleared on reset, flush and dispatch of the row.
- When undefined: no ports, no shadow; wakeup clearing is final.

Test Plan:
1. Reset: hold rst_n=0 mid-operation with 4 valid entries -> op_ready=0 immediately, with no clock required.
2. Chain dependency: dispatch e3 (no wait), then e5 with src0 waiting on e3 -> op_ready[5]=0. Wakeup_vec slot0 = onehot(3) -> op_ready[5]=1 the next cycle.
3. Same-cycle bypass: dispatch e7 waiting on e2 while wakeup_vec carries onehot(2) -> op_ready[7]=1 one cycle later.
4. Store ordering, mode 1:
   - Lane0 store to e1, lane1 predicted load to e4, same cycle -> e4 depends on e1.
   - Release e1 plus wakeup e1 -> op_ready[4]=1.
   - The same stimulus with mdp=0 gives op_ready[4]=1 immediately.
5. Flush with dispatch of e0 pending -> all op_ready=0 and e0 not valid. A store dispatched afterwards starts from an empty store vector.
6. Cancel (RSD_MATRIX_WAKEUP_CANCEL_EN): e6 waiting on e2, wakeup e2 at t, cancel_vec=onehot(2) at t+1 -> op_ready[6]=1 at t+1 and 0 at t+2. A second wakeup of e2 -> op_ready[6]=1.

Source files
------------

// File: rtl/matrix_wakeup_unit.sv
// matrix_wakeup_unit: issue-queue valid bits, producer dependency matrix and
// outstanding-store vector; produces per-entry operand-ready flags for select.
// Ports: flush clears entries; dispatch_* writes up to DISPATCH_WIDTH entries
// (lane 0 oldest); wakeup_vec clears producer columns; release_vec retires
// entries; op_ready = valid & no pending producer.
// Optional macro RSD_MATRIX_WAKEUP_CANCEL_EN adds cancel_valid/cancel_vec,
// which restore wakeup bits cleared in the previous cycle.
module matrix_wakeup_unit #(
  parameter int ENTRY_NUM      = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int SRC_NUM        = 2,
  parameter int WAKEUP_NUM     = 3,
  parameter int STORE_DEP_MODE = 1,
  localparam int IDX_W         = $clog2(ENTRY_NUM)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  logic [DISPATCH_WIDTH-1:0]               dispatch_valid,
  input  logic [DISPATCH_WIDTH*IDX_W-1:0]         dispatch_ptr,
  input  logic [DISPATCH_WIDTH*SRC_NUM-1:0]       dispatch_src_wait,
  input  logic [DISPATCH_WIDTH*SRC_NUM*IDX_W-1:0] dispatch_src_ptr,
  input  logic [DISPATCH_WIDTH-1:0]               dispatch_store,
  input  logic [DISPATCH_WIDTH-1:0]               dispatch_load,
  input  logic [DISPATCH_WIDTH-1:0]               dispatch_mdp,
  input  logic [WAKEUP_NUM*ENTRY_NUM-1:0]         wakeup_vec,
  input  logic [ENTRY_NUM-1:0]                    release_vec,
`ifdef RSD_MATRIX_WAKEUP_CANCEL_EN
  input  logic                                    cancel_valid,
  input  logic [ENTRY_NUM-1:0]                    cancel_vec,
`endif
  output logic [ENTRY_NUM-1:0]                    op_ready
);

  localparam logic [ENTRY_NUM-1:0] ONE = 1;

  logic [ENTRY_NUM-1:0] valid_q, valid_d;
  logic [ENTRY_NUM-1:0] store_q, store_d;
  logic [ENTRY_NUM-1:0] row_q [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] row_d [ENTRY_NUM];
`ifdef RSD_MATRIX_WAKEUP_CANCEL_EN
  logic [ENTRY_NUM-1:0] shadow_q [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] shadow_d [ENTRY_NUM];
`endif
  logic [ENTRY_NUM-1:0] wake;
  logic [ENTRY_NUM-1:0] col_clr;
  logic [ENTRY_NUM-1:0] sv;
  logic [ENTRY_NUM-1:0] dep;
  logic [IDX_W-1:0]     d;
  logic [IDX_W-1:0]     s;

  always_comb begin
    wake = '0;
    for (int w = 0; w < WAKEUP_NUM; w++)
      wake |= wakeup_vec[w*ENTRY_NUM +: ENTRY_NUM];
  end

  // Columns of entries being re-dispatched are cleared before the new
  // rows are written, so a same-cycle younger lane keeps its dependency
  // on an older lane's entry.
  always_comb begin
    col_clr = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      if (dispatch_valid[i] && !flush)
        col_clr |= ONE << dispatch_ptr[i*IDX_W +: IDX_W];
  end

  always_comb begin
    valid_d = valid_q & ~release_vec;
    sv      = store_q & ~release_vec;
    dep     = '0;
    d       = '0;
    s       = '0;
    for (int e = 0; e < ENTRY_NUM; e++) begin
`ifdef RSD_MATRIX_WAKEUP_CANCEL_EN
      // Restore is ORed after the wake clear so it wins over a new wakeup.
      row_d[e]    = (row_q[e] & ~wake) & ~col_clr;
      if (cancel_valid)
        row_d[e] |= shadow_q[e] & cancel_vec & ~col_clr;
      shadow_d[e] = row_q[e] & wake & ~col_clr;
`else
      row_d[e] = row_q[e] & ~wake & ~col_clr;
`endif
    end
    if (!flush) begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        if (dispatch_valid[i]) begin
          d   = dispatch_ptr[i*IDX_W +: IDX_W];
          dep = '0;
          for (int j = 0; j < SRC_NUM; j++) begin
            s = dispatch_src_ptr[(i*SRC_NUM+j)*IDX_W +: IDX_W];
            if (dispatch_src_wait[i*SRC_NUM+j])
              dep |= ONE << s;
          end
          if (STORE_DEP_MODE == 1 && dispatch_load[i] && dispatch_mdp[i])
            dep |= sv;
          if (STORE_DEP_MODE == 2 && dispatch_load[i])
            dep |= sv;
          row_d[d]   = dep & ~wake;
          valid_d[d] = 1'b1;
`ifdef RSD_MATRIX_WAKEUP_CANCEL_EN
          shadow_d[d] = '0;
`endif
          // Visible to younger lanes in this same cycle.
          if (dispatch_store[i])
            sv |= ONE << d;
        end
      end
    end
    store_d = sv;
    if (flush) begin
      valid_d = '0;
      store_d = '0;
`ifdef RSD_MATRIX_WAKEUP_CANCEL_EN
      for (int e = 0; e < ENTRY_NUM; e++)
        shadow_d[e] = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      store_q <= '0;
      for (int e = 0; e < ENTRY_NUM; e++) begin
        row_q[e] <= '0;
`ifdef RSD_MATRIX_WAKEUP_CANCEL_EN
        shadow_q[e] <= '0;
`endif
      end
    end else begin
      valid_q <= valid_d;
      store_q <= store_d;
      for (int e = 0; e < ENTRY_NUM; e++) begin
        row_q[e] <= row_d[e];
`ifdef RSD_MATRIX_WAKEUP_CANCEL_EN
        shadow_q[e] <= shadow_d[e];
`endif
      end
    end
  end

  always_comb begin
    for (int e = 0; e < ENTRY_NUM; e++)
      op_ready[e] = valid_q[e] & ~|row_q[e];
  end

endmodule

// File: tb/tb_matrix_wakeup_unit.sv
// tb_matrix_wakeup_unit: directed vectors for matrix_wakeup_unit.
// Inputs driven 1 time unit after posedge, op_ready sampled there too.
module tb_matrix_wakeup_unit;
  localparam int EN = 16;
  localparam int DW = 2;
  localparam int SN = 2;
  localparam int WN = 3;
  localparam int IW = 4;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [DW-1:0]     dispatch_valid;
  logic [DW*IW-1:0]  dispatch_ptr;
  logic [DW*SN-1:0]  dispatch_src_wait;
  logic [DW*SN*IW-1:0] dispatch_src_ptr;
  logic [DW-1:0]     dispatch_store;
  logic [DW-1:0]     dispatch_load;
  logic [DW-1:0]     dispatch_mdp;
  logic [WN*EN-1:0]  wakeup_vec;
  logic [EN-1:0]     release_vec;
`ifdef RSD_MATRIX_WAKEUP_CANCEL_EN
  logic              cancel_valid;
  logic [EN-1:0]     cancel_vec;
`endif
  logic [EN-1:0]     op_ready;

  int n_chk  = 0;
  int n_fail = 0;

  matrix_wakeup_unit #(
    .ENTRY_NUM(EN), .DISPATCH_WIDTH(DW), .SRC_NUM(SN),
    .WAKEUP_NUM(WN), .STORE_DEP_MODE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dispatch_valid(dispatch_valid),
    .dispatch_ptr(dispatch_ptr),
    .dispatch_src_wait(dispatch_src_wait),
    .dispatch_src_ptr(dispatch_src_ptr),
    .dispatch_store(dispatch_store),
    .dispatch_load(dispatch_load),
    .dispatch_mdp(dispatch_mdp),
    .wakeup_vec(wakeup_vec),
    .release_vec(release_vec),
`ifdef RSD_MATRIX_WAKEUP_CANCEL_EN
    .cancel_valid(cancel_valid),
    .cancel_vec(cancel_vec),
`endif
    .op_ready(op_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush             = 1'b0;
    dispatch_valid    = '0;
    dispatch_ptr      = '0;
    dispatch_src_wait = '0;
    dispatch_src_ptr  = '0;
    dispatch_store    = '0;
    dispatch_load     = '0;
    dispatch_mdp      = '0;
    wakeup_vec        = '0;
    release_vec       = '0;
`ifdef RSD_MATRIX_WAKEUP_CANCEL_EN
    cancel_valid      = 1'b0;
    cancel_vec        = '0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic disp(input int ln, input int ptr,
                      input logic [1:0] w,
                      input int s0, input int s1,
                      input logic st, input logic ld,
                      input logic mdp);
    dispatch_valid[ln]                  = 1'b1;
    dispatch_ptr[ln*IW +: IW]           = IW'(ptr);
    dispatch_src_wait[ln*SN +: SN]      = w;
    dispatch_src_ptr[(ln*SN)*IW +: IW]  = IW'(s0);
    dispatch_src_ptr[(ln*SN+1)*IW +: IW] = IW'(s1);
    dispatch_store[ln]                  = st;
    dispatch_load[ln]                   = ld;
    dispatch_mdp[ln]                    = mdp;
  endtask

  task automatic wake(input int slot, input int e);
    wakeup_vec[slot*EN + e] = 1'b1;
  endtask

  function automatic logic [31:0] rdy();
    return 32'(op_ready);
  endfunction

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_idle", rdy(), 32'h0);
    rst_n = 1'b1;

    disp(0, 8, 2'b00, 0, 0, 0, 0, 0);
    disp(1, 9, 2'b00, 0, 0, 0, 0, 0);
    tick();
    disp(0, 10, 2'b00, 0, 0, 0, 0, 0);
    disp(1, 11, 2'b00, 0, 0, 0, 0, 0);
    tick();
    check("four_valid", rdy(), 32'h0F00);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst", rdy(), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst", rdy(), 32'h0);

    disp(0, 3, 2'b00, 0, 0, 0, 0, 0);
    tick();
    check("e3_ready", rdy(), 32'h0008);
    disp(0, 5, 2'b01, 3, 0, 0, 0, 0);
    tick();
    check("e5_wait", rdy(), 32'h0008);
    wake(0, 3);
    tick();
    check("e5_woken", rdy(), 32'h0028);

    disp(0, 7, 2'b01, 2, 0, 0, 0, 0);
    wake(1, 2);
    tick();
    check("bypass", rdy(), 32'h00A8);
    disp(0, 9, 2'b10, 0, 2, 0, 0, 0);
    tick();
    check("e9_wait", rdy(), 32'h00A8);
    wake(2, 2);
    tick();
    check("e9_slot2", rdy(), 32'h02A8);

    release_vec = 16'h02A8;
    tick();
    check("release", rdy(), 32'h0);
    disp(0, 1, 2'b00, 0, 0, 1, 0, 0);
    disp(1, 4, 2'b00, 0, 0, 0, 1, 1);
    tick();
    check("st_ld_dep", rdy(), 32'h0002);
    release_vec[1] = 1'b1;
    wake(0, 1);
    tick();
    check("st_rel_wake", rdy(), 32'h0010);
    release_vec[4] = 1'b1;
    tick();
    check("rel_e4", rdy(), 32'h0);
    disp(0, 1, 2'b00, 0, 0, 1, 0, 0);
    disp(1, 4, 2'b00, 0, 0, 0, 1, 0);
    tick();
    check("no_mdp", rdy(), 32'h0012);
    disp(0, 6, 2'b00, 0, 0, 0, 1, 1);
    tick();
    check("mdp_later", rdy(), 32'h0012);
    wake(0, 1);
    tick();
    check("mdp_wake", rdy(), 32'h0052);

    flush = 1'b1;
    disp(0, 0, 2'b00, 0, 0, 0, 0, 0);
    tick();
    check("flush", rdy(), 32'h0);
    disp(0, 3, 2'b00, 0, 0, 0, 1, 1);
    tick();
    check("flush_stvec", rdy(), 32'h0008);
    disp(0, 2, 2'b00, 0, 0, 1, 0, 0);
    disp(1, 10, 2'b00, 0, 0, 0, 0, 0);
    release_vec[10] = 1'b1;
    tick();
    check("disp_rel", rdy(), 32'h040C);

`ifdef RSD_MATRIX_WAKEUP_CANCEL_EN
    disp(0, 6, 2'b01, 2, 0, 0, 0, 0);
    tick();
    check("c_wait", rdy(), 32'h040C);
    wake(0, 2);
    tick();
    check("c_wake", rdy(), 32'h044C);
    cancel_valid  = 1'b1;
    cancel_vec[2] = 1'b1;
    tick();
    check("c_cancel", rdy(), 32'h040C);
    wake(0, 2);
    tick();
    check("c_rewake", rdy(), 32'h044C);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
